// File: rtl/shift_share_arbiter_pkg.sv
// Shared definitions for the shift_share_arbiter slice.
//   SHIFT_W   : data width of the shared barrel shifter (8)
//   AMT_W     : shift-amount width (3, i.e. 0..7)
//   MAX_REQ   : largest supported requester count (8)
//   calc_id_w : requester-index width, never narrower than 1 bit
package shift_share_arbiter_pkg;

  localparam int SHIFT_W = 8;
  localparam int AMT_W   = 3;
  localparam int MAX_REQ = 8;

  function automatic int calc_id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/barrel_shr8.sv
// 8-bit logical-right barrel shifter, zero fill.
// Ports:
//   din  : input data
//   amt  : shift amount 0..7
//   dout : din >> amt, vacated upper bits are zero
module barrel_shr8
  import shift_share_arbiter_pkg::*;
(
  input  logic [SHIFT_W-1:0] din,
  input  logic [AMT_W-1:0]   amt,
  output logic [SHIFT_W-1:0] dout
);

  logic [SHIFT_W-1:0] s1;
  logic [SHIFT_W-1:0] s2;

  // Log shifter: stages of 1, 2 and 4 bit positions.
  assign s1   = amt[0] ? {1'b0, din[SHIFT_W-1:1]} : din;
  assign s2   = amt[1] ? {2'b0, s1[SHIFT_W-1:2]}  : s1;
  assign dout = amt[2] ? {4'b0, s2[SHIFT_W-1:4]}  : s2;

endmodule

// File: rtl/shift_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   : per-requester request vector
//   ptr   : requester with highest priority this cycle
//   en    : when low, grant is forced to zero (idx is still computed)
//   grant : one-hot-or-zero grant
//   idx   : encoded index of the first requester found at or after ptr
module shift_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);

  logic found;
  int   pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    // Walk the ring starting at ptr; the first active request wins.
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        idx        = ID_W'(pos);
        grant[pos] = en;
      end
    end
  end

endmodule

// File: rtl/shift_share_arbiter.sv
// Shares one 8-bit logical-right barrel shifter among NUM_REQ requesters
// with round-robin arbitration and a single registered result stage
// (1-cycle latency, one shift per cycle sustained).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid          : per-requester valid
//   req_data           : flat bus, requester i on [8i+7:8i]
//   req_amt            : flat bus, requester i on [3i+2:3i]
//   req_ready          : one-hot-or-zero acceptance (combinational)
//   out_valid/out_data/out_id/out_ready : result handshake
// Optional (macro SHIFT_SHARE_STATS_EN):
//   accept_cnt         : saturating count of accepted requests
//   stall_cnt          : saturating count of cycles with a request pending
//                        while the result register cannot accept
module shift_share_arbiter
  import shift_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*SHIFT_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]   req_amt,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [SHIFT_W-1:0]         out_data,
  output logic [ID_W-1:0]            out_id,
  input  logic                       out_ready
`ifdef SHIFT_SHARE_STATS_EN
  ,
  output logic [15:0]                accept_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] i);
    return (i == ID_W'(NUM_REQ - 1)) ? '0 : i + ID_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic                 vld_p1;
  logic [SHIFT_W-1:0]   data_p1;
  logic [ID_W-1:0]      id_p1;
  logic [ID_W-1:0]      rr_ptr;

  logic                 can_accept;
  logic                 xfer;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      win_idx;
  logic [SHIFT_W-1:0]   win_data_p0;
  logic [AMT_W-1:0]     win_amt_p0;
  logic [SHIFT_W-1:0]   shifted_p0;

  // ---- stage p0: arbitrate, select winner, shift ----
  // The result register frees up either when empty or when drained this cycle.
  assign can_accept = !vld_p1 || out_ready;

  shift_rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (can_accept),
    .grant (grant),
    .idx   (win_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    win_data_p0 = '0;
    win_amt_p0  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_data_p0 = req_data[i*SHIFT_W +: SHIFT_W];
        win_amt_p0  = req_amt[i*AMT_W +: AMT_W];
      end
    end
  end

  barrel_shr8 u_shift (
    .din  (win_data_p0),
    .amt  (win_amt_p0),
    .dout (shifted_p0)
  );

  // ---- stage p1: result register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      // Also covers drain-and-refill in the same cycle: no bubble.
      vld_p1  <= 1'b1;
      data_p1 <= shifted_p0;
      id_p1   <= win_idx;
      rr_ptr  <= next_ptr(win_idx);
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_id    = id_p1;

`ifdef SHIFT_SHARE_STATS_EN
  logic [15:0] acc_cnt_p1;
  logic [15:0] stl_cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_p1 <= '0;
      stl_cnt_p1 <= '0;
    end else begin
      if (xfer)
        acc_cnt_p1 <= sat_inc16(acc_cnt_p1);
      if ((|req_valid) && !can_accept)
        stl_cnt_p1 <= sat_inc16(stl_cnt_p1);
    end
  end

  assign accept_cnt = acc_cnt_p1;
  assign stall_cnt  = stl_cnt_p1;
`endif

endmodule

// File: tb/tb_shift_share_arbiter.sv
// Testbench for shift_share_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked against a reference
// model that picks winners by ring distance from the priority pointer.
module tb_shift_share_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*8-1:0]   req_data;
  logic [N*3-1:0]   req_amt;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [IDW-1:0]   out_id;
  logic             out_ready;
`ifdef SHIFT_SHARE_STATS_EN
  logic [15:0]      accept_cnt;
  logic [15:0]      stall_cnt;
`endif

  shift_share_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready)
`ifdef SHIFT_SHARE_STATS_EN
    ,
    .accept_cnt (accept_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic         m_valid;
  logic [7:0]   m_data;
  int           m_id;
  int           m_ptr;
  logic [N-1:0] m_ready;
  int           m_acc;
  int           m_stall;

  task automatic mdl_reset();
    m_valid = 1'b0; m_data = 8'h00; m_id = 0; m_ptr = 0;
    m_acc = 0; m_stall = 0;
  endtask

  // Winner = valid requester with the smallest ring distance from the pointer.
  function automatic logic [N-1:0] mdl_pick(input logic [N-1:0] v, input int p, input logic can);
    int best = -1;
    int bd   = N;
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    if (can && best >= 0) r[best] = 1'b1;
    return r;
  endfunction

  task automatic mdl_step();
    logic can;
    can = !m_valid || out_ready;
    if (|m_ready && m_acc < 65535) m_acc++;
    if (|req_valid && !can && m_stall < 65535) m_stall++;
    if (|m_ready) begin
      for (int i = 0; i < N; i++)
        if (m_ready[i]) begin
          m_data  = req_data[i*8 +: 8] >> req_amt[i*3 +: 3];
          m_id    = i;
          m_valid = 1'b1;
          m_ptr   = (i + 1) % N;
        end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial mdl_reset();

  // Per-cycle compare: ready just after inputs settle, outputs just after the edge.
  initial begin
    m_ready = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) mdl_reset();
      m_ready = mdl_pick(req_valid, m_ptr, !m_valid || out_ready);
      chk("req_ready", req_ready, m_ready);
      @(posedge clk); #1;
      if (!rst_n) mdl_reset();
      else        mdl_step();
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_id);
`ifdef SHIFT_SHARE_STATS_EN
      chk("accept_cnt", accept_cnt, m_acc);
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a);
    req_data[i*8 +: 8] = d;
    req_amt[i*3 +: 3]  = a;
  endtask

  task automatic one_shot(input int i, input logic [7:0] d, input logic [2:0] a,
                          input logic [7:0] exp, input string nm);
    @(negedge clk);
    req_valid = '0; req_valid[i] = 1'b1; set_req(i, d, a); out_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    #3 chk(nm, out_data, exp);
  endtask

  logic [7:0]   d0;
  logic [N-1:0] acc;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_amt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);

    // single requester 2: 0xB4 >> 3 = 0x16
    @(negedge clk);
    req_valid = 4'b0100; set_req(2, 8'hB4, 3'd3); out_ready = 1'b1;
    #3 chk("single_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #3;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'h16);
    chk("single_id", out_id, 2);

    // amount boundaries
    one_shot(1, 8'h81, 3'd0, 8'h81, "amt0");
    one_shot(3, 8'h81, 3'd7, 8'h01, "amt7");
    one_shot(0, 8'h7F, 3'd7, 8'h00, "amt7_zero");

    // asynchronous reset mid-stream while a result is held
    chk("pre_rst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_id", out_id, 0);

    // round robin: all valid, no backpressure
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 3'($urandom));
    req_valid = 4'hF; out_ready = 1'b1;
    #3 chk("rr_first_grant", req_ready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #3;
      chk("rr_valid", out_valid, 1);
      chk("rr_id", out_id, k % N);
    end

    // backpressure with requester 1
    @(negedge clk);
    req_valid = 4'b0010; out_ready = 1'b0;
    d0 = out_data;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("bp_ready", req_ready, 0);
      chk("bp_data_hold", out_data, d0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #3 chk("bp_release_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #3 chk("bp_release_id", out_id, 1);

    // randomized traffic honouring the hold-until-accepted rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & m_ready;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, 8'($urandom), 3'($urandom));
        end
      end
    end
    @(negedge clk);
    req_valid = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

`ifdef SHIFT_SHARE_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0001; set_req(0, 8'h55, 3'd1); out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    req_valid = '0;
    #3;
    chk("stats_accept10", accept_cnt, 10);
    chk("stats_stall4", stall_cnt, 4);
    @(negedge clk);
    req_valid = 4'hF; out_ready = 1'b1;
    repeat (70000) @(negedge clk);
    req_valid = '0;
    #3 chk("stats_accept_sat", accept_cnt, 16'hFFFF);
    @(negedge clk);
`endif

    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
